// File: rtl/painterengine_gpu_dma_arbiter.sv
// Round-robin owner arbitration of one shared DMA reader/writer/FIFO
// among N_REQ GPU engines, with routed completions and a hang watchdog.
module painterengine_gpu_dma_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                 i_wire_clock,
  input  logic                 i_wire_reset,
  input  logic [N_REQ-1:0]     i_wire_req,
  input  logic [N_REQ-1:0]     i_wire_release,
  input  logic [N_REQ-1:0]     i_wire_req_fifo_resetn,
  input  logic [N_REQ-1:0]     i_wire_req_reader_resetn,
  input  logic [32*N_REQ-1:0]  i_wire_req_reader_address,
  input  logic [32*N_REQ-1:0]  i_wire_req_reader_length,
  input  logic [N_REQ-1:0]     i_wire_req_writer_resetn,
  input  logic [32*N_REQ-1:0]  i_wire_req_writer_address,
  input  logic [32*N_REQ-1:0]  i_wire_req_writer_length,
  output logic [N_REQ-1:0]     o_wire_grant,
  output logic [N_REQ-1:0]     o_wire_req_reader_done,
  output logic [N_REQ-1:0]     o_wire_req_reader_error,
  output logic [N_REQ-1:0]     o_wire_req_writer_done,
  output logic [N_REQ-1:0]     o_wire_req_writer_error,
  output logic                 o_wire_fifo_resetn,
  output logic                 o_wire_dma_reader_resetn,
  output logic [31:0]          o_wire_dma_reader_address,
  output logic [31:0]          o_wire_dma_reader_length,
  input  logic                 i_wire_dma_reader_done,
  input  logic                 i_wire_dma_reader_error,
  output logic                 o_wire_dma_writer_resetn,
  output logic [31:0]          o_wire_dma_writer_address,
  output logic [31:0]          o_wire_dma_writer_length,
  input  logic                 i_wire_dma_writer_done,
  input  logic                 i_wire_dma_writer_error,
  output logic [31:0]          o_wire_state
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_W:0]   NQ = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_REQ-1);
  localparam logic [31:0]      WD_LIMIT = 32'(TIMEOUT);

  typedef enum logic [7:0] {
    IDLE    = 8'h00,
    GRANT   = 8'h01,
    OWNED   = 8'h02,
    RELEASE = 8'h03,
    TMO_ERR = 8'h04
  } state_t;

  state_t state, state_nx;

  logic [IDX_W-1:0] owner, last_owner, pick;
  logic [IDX_W:0]   cand;
  logic             found;
  logic [31:0]      wdog;
  logic [N_REQ-1:0] own_oh;
  logic             own_req, own_rel;
  logic             sel_fifo, sel_rd_rstn, sel_wr_rstn;
  logic [31:0]      sel_rd_addr, sel_rd_len, sel_wr_addr, sel_wr_len;
  logic             rd_busy, wr_busy, any_evt, wd_active;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_owner} + (IDX_W+1)'(i);
      if (cand >= NQ) cand = cand - NQ;
      if (!found && i_wire_req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        pick  = cand[IDX_W-1:0];
      end
    end
  end

  assign own_oh  = N_REQ'(1) << owner;
  assign own_req = |(i_wire_req & own_oh);
  assign own_rel = |(i_wire_release & own_oh);

  always_comb begin
    sel_fifo    = 1'b0;
    sel_rd_rstn = 1'b0;
    sel_wr_rstn = 1'b0;
    sel_rd_addr = '0;
    sel_rd_len  = '0;
    sel_wr_addr = '0;
    sel_wr_len  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner == IDX_W'(k)) begin
        sel_fifo    = i_wire_req_fifo_resetn[k];
        sel_rd_rstn = i_wire_req_reader_resetn[k];
        sel_wr_rstn = i_wire_req_writer_resetn[k];
        sel_rd_addr = i_wire_req_reader_address[32*k +: 32];
        sel_rd_len  = i_wire_req_reader_length[32*k +: 32];
        sel_wr_addr = i_wire_req_writer_address[32*k +: 32];
        sel_wr_len  = i_wire_req_writer_length[32*k +: 32];
      end
    end
  end

  assign rd_busy = sel_rd_rstn & ~i_wire_dma_reader_done
                 & ~i_wire_dma_reader_error;
  assign wr_busy = sel_wr_rstn & ~i_wire_dma_writer_done
                 & ~i_wire_dma_writer_error;
  assign any_evt = i_wire_dma_reader_done | i_wire_dma_reader_error
                 | i_wire_dma_writer_done | i_wire_dma_writer_error;
  assign wd_active = (rd_busy | wr_busy) & ~any_evt;

  // Release/request-drop wins over a simultaneous watchdog expiry.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = GRANT;
      GRANT:   state_nx = OWNED;
      OWNED: begin
        if (own_rel || !own_req)   state_nx = RELEASE;
        else if (wdog == WD_LIMIT) state_nx = TMO_ERR;
      end
      TMO_ERR: if (own_rel || !own_req) state_nx = RELEASE;
      RELEASE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_wire_clock) begin
    if (i_wire_reset) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= LAST_INIT;
      wdog       <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) owner <= pick;
      if (state == RELEASE) last_owner <= owner;
      if (state == OWNED && wd_active)
        wdog <= (wdog == 32'hFFFF_FFFF) ? wdog : wdog + 32'd1;
      else
        wdog <= '0;
    end
  end

  always_comb begin
    o_wire_grant              = '0;
    o_wire_req_reader_done    = '0;
    o_wire_req_reader_error   = '0;
    o_wire_req_writer_done    = '0;
    o_wire_req_writer_error   = '0;
    o_wire_fifo_resetn        = 1'b0;
    o_wire_dma_reader_resetn  = 1'b0;
    o_wire_dma_reader_address = '0;
    o_wire_dma_reader_length  = '0;
    o_wire_dma_writer_resetn  = 1'b0;
    o_wire_dma_writer_address = '0;
    o_wire_dma_writer_length  = '0;
    o_wire_state              = '0;
    if (!i_wire_reset) begin
      o_wire_state = {16'd0, {(8-IDX_W){1'b0}}, owner, state};
      if (state == GRANT || state == OWNED || state == TMO_ERR)
        o_wire_grant = own_oh;
      if (state == OWNED) begin
        o_wire_fifo_resetn        = sel_fifo;
        o_wire_dma_reader_resetn  = sel_rd_rstn;
        o_wire_dma_reader_address = sel_rd_addr;
        o_wire_dma_reader_length  = sel_rd_len;
        o_wire_dma_writer_resetn  = sel_wr_rstn;
        o_wire_dma_writer_address = sel_wr_addr;
        o_wire_dma_writer_length  = sel_wr_len;
        o_wire_req_reader_done  = i_wire_dma_reader_done  ? own_oh : '0;
        o_wire_req_reader_error = i_wire_dma_reader_error ? own_oh : '0;
        o_wire_req_writer_done  = i_wire_dma_writer_done  ? own_oh : '0;
        o_wire_req_writer_error = i_wire_dma_writer_error ? own_oh : '0;
      end
      if (state == TMO_ERR) begin
        o_wire_req_reader_error = own_oh;
        o_wire_req_writer_error = own_oh;
      end
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_dma_arbiter.sv
// Scoreboard bench: stimulus queues expected grants, passthrough and
// routed completions; a negedge monitor pops and compares them.
module tb_painterengine_gpu_dma_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    req, rel, fifo_rstn, rd_rstn, wr_rstn;
  logic [32*N-1:0] rd_addr, rd_len, wr_addr, wr_len;
  logic [N-1:0]    grant, rd_done_o, rd_err_o, wr_done_o, wr_err_o;
  logic            fifo_o, rd_rstn_o, wr_rstn_o;
  logic [31:0]     rd_addr_o, rd_len_o, wr_addr_o, wr_len_o, state_o;
  logic            dma_rd_done, dma_rd_err, dma_wr_done, dma_wr_err;

  painterengine_gpu_dma_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .i_wire_clock              (clk),
    .i_wire_reset              (rst),
    .i_wire_req                (req),
    .i_wire_release            (rel),
    .i_wire_req_fifo_resetn    (fifo_rstn),
    .i_wire_req_reader_resetn  (rd_rstn),
    .i_wire_req_reader_address (rd_addr),
    .i_wire_req_reader_length  (rd_len),
    .i_wire_req_writer_resetn  (wr_rstn),
    .i_wire_req_writer_address (wr_addr),
    .i_wire_req_writer_length  (wr_len),
    .o_wire_grant              (grant),
    .o_wire_req_reader_done    (rd_done_o),
    .o_wire_req_reader_error   (rd_err_o),
    .o_wire_req_writer_done    (wr_done_o),
    .o_wire_req_writer_error   (wr_err_o),
    .o_wire_fifo_resetn        (fifo_o),
    .o_wire_dma_reader_resetn  (rd_rstn_o),
    .o_wire_dma_reader_address (rd_addr_o),
    .o_wire_dma_reader_length  (rd_len_o),
    .i_wire_dma_reader_done    (dma_rd_done),
    .i_wire_dma_reader_error   (dma_rd_err),
    .o_wire_dma_writer_resetn  (wr_rstn_o),
    .o_wire_dma_writer_address (wr_addr_o),
    .o_wire_dma_writer_length  (wr_len_o),
    .i_wire_dma_writer_done    (dma_wr_done),
    .i_wire_dma_writer_error   (dma_wr_err),
    .o_wire_state              (state_o)
  );

  typedef struct packed {
    logic [2:0]  rstn;
    logic [31:0] ra, rl, wa, wl;
  } pass_t;

  logic [3:0]  grant_q[$];
  logic [15:0] route_q[$];
  pass_t       pass_q[$];

  int checks = 0;
  int passes = 0;
  int last_model = N - 1;
  int cur = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int rr_pick(input logic [3:0] p, input int last);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (last + i) % N;
      if (p[c]) return c;
    end
    return 0;
  endfunction

  task automatic randomize_engines();
    for (int k = 0; k < N; k++) begin
      rd_addr[32*k +: 32] = $urandom();
      rd_len[32*k +: 32]  = $urandom();
      wr_addr[32*k +: 32] = $urandom();
      wr_len[32*k +: 32]  = $urandom();
    end
    fifo_rstn = 4'($urandom());
    rd_rstn   = 4'($urandom());
    wr_rstn   = 4'($urandom());
  endtask

  task automatic issue(input logic [3:0] p);
    int w;
    pass_t e;
    w = rr_pick(p, last_model);
    e.rstn = {fifo_rstn[w], rd_rstn[w], wr_rstn[w]};
    e.ra = rd_addr[32*w +: 32];
    e.rl = rd_len[32*w +: 32];
    e.wa = wr_addr[32*w +: 32];
    e.wl = wr_len[32*w +: 32];
    grant_q.push_back(4'(1 << w));
    pass_q.push_back(e);
    req = p;
    last_model = w;
    cur = w;
  endtask

  task automatic drive_pulses(input bit owned);
    logic a, b, c, d;
    logic [3:0] m;
    a = ($urandom_range(0, 3) == 0);
    b = ($urandom_range(0, 3) == 0);
    c = ($urandom_range(0, 3) == 0);
    d = ($urandom_range(0, 3) == 0);
    m = 4'(1 << cur);
    dma_rd_done = a;
    dma_rd_err  = b;
    dma_wr_done = c;
    dma_wr_err  = d;
    if (owned && (a | b | c | d))
      route_q.push_back({a ? m : 4'd0, b ? m : 4'd0,
                         c ? m : 4'd0, d ? m : 4'd0});
  endtask

  task automatic clear_pulses();
    dma_rd_done = 1'b0;
    dma_rd_err  = 1'b0;
    dma_wr_done = 1'b0;
    dma_wr_err  = 1'b0;
  endtask

  task automatic wait_state(input logic [7:0] st);
    int n;
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n < 30 && !ok) begin
      @(negedge clk);
      ok = (state_o[7:0] == st);
      n++;
    end
    if (!ok) check("wait_state", {24'd0, state_o[7:0]}, {24'd0, st});
  endtask

  task automatic owned_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      drive_pulses(1'b1);
      rel = 4'($urandom()) & ~4'(1 << cur);
    end
  endtask

  task automatic end_round(input logic [3:0] next_p, input bit has_next);
    bit drop;
    logic [3:0] p;
    @(posedge clk); #1;
    drive_pulses(1'b1);
    drop = 1'($urandom_range(0, 1));
    rel = drop ? 4'd0 : (4'(1 << cur) | (4'($urandom()) & ~4'(1 << cur)));
    if (has_next) begin
      p = next_p;
      if (drop) begin
        p = p & ~4'(1 << cur);
        if (p == 4'd0) p = 4'(1 << ((cur + 1) % N));
      end
      randomize_engines();
      issue(p);
    end else begin
      req = 4'd0;
    end
    @(posedge clk); #1;
    rel = 4'd0;
    drive_pulses(1'b0);
    @(negedge clk);
    check("gap_release_grant", {28'd0, grant}, 32'd0);
    check("gap_release_state", {24'd0, state_o[7:0]}, 32'h03);
    @(posedge clk); #1;
    drive_pulses(1'b0);
    @(negedge clk);
    check("gap_idle_grant", {28'd0, grant}, 32'd0);
    if (has_next) begin
      @(posedge clk); #1;
      drive_pulses(1'b0);
      @(negedge clk);
      check("handover_grant", {28'd0, grant}, 32'(1 << cur));
      check("handover_dma_rstn", {31'd0, rd_rstn_o}, 32'd0);
      @(posedge clk); #1;
      clear_pulses();
      @(negedge clk);
      check("handover_owned", {24'd0, state_o[7:0]}, 32'h02);
    end else begin
      @(posedge clk); #1;
      clear_pulses();
    end
  endtask

  logic [3:0] prev_grant = 4'd0;
  logic [7:0] prev_st = 8'd0;

  always @(negedge clk) begin
    logic [15:0] routed;
    routed = {rd_done_o, rd_err_o, wr_done_o, wr_err_o};
    if (routed != 16'd0 && state_o[7:0] != 8'h04) begin
      if (route_q.size() == 0)
        check("route_unexpected", {16'd0, routed}, 32'd0);
      else
        check("route", {16'd0, routed}, {16'd0, route_q.pop_front()});
    end
    if (grant != 4'd0 && prev_grant == 4'd0) begin
      if (grant_q.size() == 0)
        check("grant_unexpected", {28'd0, grant}, 32'd0);
      else
        check("grant", {28'd0, grant}, {28'd0, grant_q.pop_front()});
    end
    if (state_o[7:0] == 8'h02 && prev_st != 8'h02) begin
      if (pass_q.size() == 0) begin
        check("pass_unexpected", {24'd0, state_o[7:0]}, 32'd0);
      end else begin
        pass_t e;
        e = pass_q.pop_front();
        check("pass_rstn", {29'd0, fifo_o, rd_rstn_o, wr_rstn_o},
              {29'd0, e.rstn});
        check("pass_rd_addr", rd_addr_o, e.ra);
        check("pass_rd_len", rd_len_o, e.rl);
        check("pass_wr_addr", wr_addr_o, e.wa);
        check("pass_wr_len", wr_len_o, e.wl);
      end
    end
    prev_grant = grant;
    prev_st = state_o[7:0];
  end

  initial begin
    int n;
    rst = 1'b1;
    req = '0;
    rel = '0;
    fifo_rstn = '0;
    rd_rstn = '0;
    wr_rstn = '0;
    rd_addr = '0;
    rd_len = '0;
    wr_addr = '0;
    wr_len = '0;
    clear_pulses();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", state_o, 32'd0);
    check("reset_grant", {28'd0, grant}, 32'd0);
    check("reset_dma", {30'd0, rd_rstn_o, fifo_o} | rd_addr_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single requester from reset
    randomize_engines();
    issue(4'b0100);
    @(posedge clk);
    @(negedge clk);
    check("t1_grant", {28'd0, grant}, 32'h4);
    @(posedge clk);
    @(negedge clk);
    check("t1_state", state_o, 32'h0000_0202);
    owned_cycles($urandom_range(1, 6));

    for (int r = 0; r < 25; r++) begin
      end_round((r < 5) ? 4'hF : 4'($urandom_range(1, 15)), 1'b1);
      owned_cycles($urandom_range(1, 8));
    end
    end_round(4'd0, 1'b0);

    // watchdog expiry on a reader that never completes
    @(posedge clk); #1;
    randomize_engines();
    rd_rstn[0] = 1'b1;
    wr_rstn[0] = 1'b0;
    issue(4'b0001);
    wait_state(8'h02);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (state_o[7:0] != 8'h02) break;
      n++;
    end
    check("wdog_owned_cycles", 32'(n), 32'(TMO + 1));
    check("tmo_state", state_o, 32'h0000_0004);
    check("tmo_dma_rstn", {31'd0, rd_rstn_o}, 32'd0);
    check("tmo_grant", {28'd0, grant}, 32'h1);
    check("tmo_errors", {24'd0, rd_err_o, wr_err_o}, 32'h11);
    @(posedge clk); #1;
    rel = 4'b0001;
    req = 4'd0;
    @(posedge clk); #1;
    rel = 4'd0;
    @(negedge clk);
    check("tmo_release", state_o, 32'h0000_0003);
    @(negedge clk);
    check("tmo_idle", state_o, 32'h0000_0000);

    // reset while a transfer is in flight
    @(posedge clk); #1;
    randomize_engines();
    issue(4'hF);
    wait_state(8'h02);
    owned_cycles(3);
    @(posedge clk); #1;
    rst = 1'b1;
    rel = '0;
    clear_pulses();
    dma_rd_done = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_state", state_o, 32'd0);
    check("mid_reset_grant", {28'd0, grant}, 32'd0);
    check("mid_reset_route", {16'd0, rd_done_o, rd_err_o, wr_done_o,
                              wr_err_o}, 32'd0);
    check("mid_reset_dma", rd_addr_o | wr_len_o |
          {29'd0, rd_rstn_o, wr_rstn_o, fifo_o}, 32'd0);
    last_model = N - 1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_pulses();
    randomize_engines();
    issue(4'hF);
    wait_state(8'h01);
    check("post_reset_grant", {28'd0, grant}, 32'h1);
    wait_state(8'h02);
    owned_cycles(2);
    end_round(4'd0, 1'b0);
    repeat (2) @(negedge clk);
    check("queues_empty",
          32'(grant_q.size() + route_q.size() + pass_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/painterengine_gpu_dma_arbiter.md
Name: painterengine_gpu_dma_arbiter

Overview:
Shares one DMA reader, one DMA writer and the FIFO between N_REQ GPU engines (memcpy, colorconvert, fill, blit). Each engine drives its own DMA resetn/address/length, exactly as it would for a private DMA pair. The arbiter grants one owner at a time in round-robin order and muxes that owner onto the shared DMA. It routes done/error back to the owner only, and a watchdog aborts a hung transfer.

Parameters:
N_REQ, 4, number of requesting engines (2..16)
TIMEOUT, 65535, max cycles a DMA leg may stay released without done/error

Ports:
i_wire_clock  in  1  clock
i_wire_reset  in  1  synchronous active-high reset
i_wire_req  in  N_REQ  engine k requests ownership (level)
i_wire_release  in  N_REQ  engine k finished its task; one-cycle pulse
i_wire_req_fifo_resetn  in  N_REQ  per-engine fifo resetn
i_wire_req_reader_resetn  in  N_REQ  per-engine reader resetn
i_wire_req_reader_address  in  32*N_REQ  packed, engine k at [32k+31:32k]
i_wire_req_reader_length  in  32*N_REQ  packed
i_wire_req_writer_resetn  in  N_REQ  per-engine writer resetn
i_wire_req_writer_address  in  32*N_REQ  packed
i_wire_req_writer_length  in  32*N_REQ  packed
o_wire_grant  out  N_REQ  one-hot owner, 0 when none
o_wire_req_reader_done  out  N_REQ  routed reader done
o_wire_req_reader_error  out  N_REQ  routed reader error
o_wire_req_writer_done  out  N_REQ  routed writer done
o_wire_req_writer_error  out  N_REQ  routed writer error
o_wire_fifo_resetn  out  1  shared fifo resetn
o_wire_dma_reader_resetn  out  1  shared reader resetn
o_wire_dma_reader_address  out  32  shared reader address
o_wire_dma_reader_length  out  32  shared reader length
i_wire_dma_reader_done  in  1  reader done
i_wire_dma_reader_error  in  1  reader error
o_wire_dma_writer_resetn  out  1  shared writer resetn
o_wire_dma_writer_address  out  32  shared writer address
o_wire_dma_writer_length  out  32  shared writer length
i_wire_dma_writer_done  in  1  writer done
i_wire_dma_writer_error  in  1  writer error
o_wire_state  out  32  {16'd0, owner[7:0], state[7:0]}

Behaviour:
- States: IDLE 8'h00, GRANT 8'h01, OWNED 8'h02, RELEASE 8'h03, TIMEOUT_ERROR 8'h04.
- Reset, and every cycle reset is high (including mid-transfer):
  - state=IDLE, owner=0, last_owner=N_REQ-1, watchdog=0.
  - All outputs 0: resetn outputs held low, address/length 0, grant 0, routed done/error 0.
- IDLE:
  - Shared DMA and fifo held in reset.
  - If any i_wire_req bit is set, pick the first set bit scanning from last_owner+1 upward with wrap, latch it into owner, and go to GRANT.
- GRANT: o_wire_grant = one-hot(owner). The DMA is still held in reset for this cycle. Next state is OWNED.
- OWNED:
  - Shared resetn/address/length = owner's inputs, combinational mux on the owner register. Non-owners' inputs are ignored.
  - Routed done/error = shared DMA done/error, on bit [owner] only, same cycle, combinational. All other bits are 0.
  - Watchdog: increments while (reader resetn==1 and no reader done/error) or (writer resetn==1 and no writer done/error). It clears to 0 when both legs are held in reset or on any done/error. Width is 32 bits, saturating.
  - watchdog==TIMEOUT goes to TIMEOUT_ERROR.
  - i_wire_release[owner] or !i_wire_req[owner] goes to RELEASE. This has priority over timeout when both occur in the same cycle.
  - A done arriving in the same cycle as release is still forwarded that cycle.
- TIMEOUT_ERROR:
  - Shared DMA and fifo forced into reset; grant held.
  - o_wire_req_reader_error[owner] and o_wire_req_writer_error[owner] held at 1.
  - Leaves to RELEASE on release or request drop.
- RELEASE:
  - DMA and fifo forced into reset; grant 0; last_owner<=owner; watchdog<=0.
  - Next state is IDLE.
- Handover latency:
  - Release sampled at cycle t, next grant visible at t+3, DMA passthrough at t+4.
  - The shared DMA is always held in reset for at least 3 cycles between owners.
- Grant is registered and never changes outside GRANT/RELEASE transitions. No preemption.
- Release pulses and other engines' inputs are ignored unless the engine is the owner.

Test Plan:
1. Reset, then i_wire_req=4'b0100 at cycle c -> grant=4'b0100 at c+1; reader address/length pass through from c+2; state reads 32'h0000_0202.
2. i_wire_req=4'hF, each engine releases after one reader+writer transfer -> grant sequence 0001, 0010, 0100, 1000, 0001, with grant 0 in each RELEASE/IDLE gap.
3. Owner=1, pulse i_wire_dma_reader_done -> o_wire_req_reader_done=4'b0010 in the same cycle, all other done/error bits 0.
4. TIMEOUT=16, owner 0 raises reader resetn with no done -> after 16 counting cycles state=0x04, o_wire_dma_reader_resetn=0, o_wire_req_reader_error[0]=1; release -> IDLE.
5. Owner 2 pulses release while engine 3 requests -> grant 0 for cycles t+1..t+2, grant=4'b1000 at t+3.
6. Assert i_wire_reset mid-OWNED while data is moving -> next edge: all outputs 0, o_wire_state=0; after deassert with req=4'hF -> grant=4'b0001 first.
